// File: rtl/reg_hist_fpga_if.sv
// Bus bundle for reg_hist_fpga: load/pop/clear controls, history read port and
// the registered word, tag and event pulses.
interface reg_hist_fpga_if #(
  parameter int DW    = 64,
  parameter int TW    = 4,
  parameter int DEPTH = 4
) ();
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          E;
  logic [DW-1:0] data;
  logic          pop;
  logic          clr;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] q;
  logic [TW-1:0] q3;
  logic [DW-1:0] hist_q;
  logic          hist_vld;
  logic [CW-1:0] cnt;
  logic          upd;
  logic          chg;
  logic          err;

  modport master (
    output E, data, pop, clr, rd_idx,
    input  q, q3, hist_q, hist_vld, cnt, upd, chg, err
  );

  modport slave (
    input  E, data, pop, clr, rd_idx,
    output q, q3, hist_q, hist_vld, cnt, upd, chg, err
  );
endinterface

// File: rtl/reg_hist_fpga.sv
// Load/hold register with tag extraction and a DEPTH-entry shift history
// supporting one-step rollback, history clear and load/tag-change pulses.
module reg_hist_fpga #(
  parameter int DW    = 64,
  parameter int TW    = 4,
  parameter int TLSB  = 60,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            R,
  reg_hist_fpga_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("reg_hist_fpga: DEPTH must be a power of 2 and at least 2");
  end
  if (TLSB + TW > DW) begin : g_bad_tag
    $error("reg_hist_fpga: tag field exceeds data width");
  end

  logic [DW-1:0] r_hist [DEPTH];
  logic [CW-1:0] r_cnt;
  logic          r_upd;
  logic          r_chg;
  logic          r_err;

  logic [TW-1:0] w_tag_in;
  logic [TW-1:0] w_tag_cur;
  logic          w_rd_vld;

  assign w_tag_in  = bus.data[TLSB +: TW];
  assign w_tag_cur = r_hist[0][TLSB +: TW];
  assign w_rd_vld  = {1'b0, bus.rd_idx} < r_cnt;

  // Entry 0 is the current word, so q/q3 come straight from it.
  assign bus.q        = r_hist[0];
  assign bus.q3       = w_tag_cur;
  assign bus.hist_q   = w_rd_vld ? r_hist[bus.rd_idx] : '0;
  assign bus.hist_vld = w_rd_vld;
  assign bus.cnt      = r_cnt;
  assign bus.upd      = r_upd;
  assign bus.chg      = r_chg;
  assign bus.err      = r_err;

  // NOTE: non-blocking assignments so every entry shifts from its pre-edge neighbour.
  always_ff @(posedge clk) begin
    if (R) begin
      // NOTE: the history is reset too, since unused entries must read back as 0.
      for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
      r_cnt <= '0;
      r_upd <= 1'b0;
      r_chg <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      r_chg <= 1'b0;
      r_err <= 1'b0;
      if (bus.E) begin
        r_hist[0] <= bus.data;
        for (int k = 1; k < DEPTH; k++) r_hist[k] <= bus.clr ? '0 : r_hist[k-1];
        if (bus.clr)                    r_cnt <= CW'(1);
        else if (r_cnt != CW'(DEPTH))   r_cnt <= r_cnt + CW'(1);
        r_upd <= 1'b1;
        r_chg <= (r_cnt == '0) || (w_tag_in != w_tag_cur);
      end else if (bus.clr) begin
        for (int k = 1; k < DEPTH; k++) r_hist[k] <= '0;
        if (r_cnt > CW'(1)) r_cnt <= CW'(1);
      end else if (bus.pop) begin
        if (r_cnt >= CW'(2)) begin
          for (int k = 0; k < DEPTH - 1; k++) r_hist[k] <= r_hist[k+1];
          r_hist[DEPTH-1] <= '0;
          r_cnt <= r_cnt - CW'(1);
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end
endmodule
